// File: rtl/saida_dados.sv
// Output peripheral: converts the processor's OUT value to decimal on 7-segment displays
// and stalls the processor until the operator presses enter. Define SAIDA_SINAL_EN for signed values.
module saida_dados #(
   parameter int DATA_W     = 18,
   parameter int NUM_DIGITS = 6
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    escrever,
   input  logic [DATA_W-1:0]       dado,
   input  logic                    enter,
   output logic                    ocupado,
   output logic                    liberado,
   output logic [7*NUM_DIGITS-1:0] displays,
   output logic                    negativo
);

   localparam int BCD_W = 4*(NUM_DIGITS+1);
   localparam int CNT_W = $clog2(DATA_W+1);
   localparam logic [CNT_W-1:0] CNT_FIM = CNT_W'(DATA_W);
   localparam logic [6:0] SEG_APAGADO = 7'h7F;
   localparam logic [6:0] SEG_TRACO   = 7'b0111111;

   typedef enum logic [1:0] {
      OCIOSO   = 2'd0,
      CONVERTE = 2'd1,
      ESPERA   = 2'd2
   } estado_t;

   estado_t                estado_r, estado_s;
   logic [DATA_W-1:0]      shift_r, shift_s;
   logic [BCD_W-1:0]       bcd_r, bcd_s, bcd_aj_s;
   logic [CNT_W-1:0]       cnt_r, cnt_s;
   logic                   estouro_r, estouro_s;
   logic                   sinal_r, sinal_s;
   logic                   enter_q_r;
   logic                   ocupado_r, ocupado_s;
   logic                   liberado_r, liberado_s;
   logic [7*NUM_DIGITS-1:0] displays_r, displays_s;
   logic                   negativo_r, negativo_s;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = SEG_APAGADO;
      endcase
      return s;
   endfunction

   function automatic logic [BCD_W-1:0] soma3(input logic [BCD_W-1:0] b);
      logic [BCD_W-1:0] r;
      r = b;
      for (int i = 0; i < NUM_DIGITS+1; i++) begin
         if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
         else                     r[4*i +: 4] = r[4*i +: 4];
      end
      return r;
   endfunction

   // Leading zeros are blanked from the most significant digit down; digit 0 always shows.
   function automatic logic [7*NUM_DIGITS-1:0] codifica(input logic [BCD_W-1:0] b,
                                                        input logic estouro);
      logic [7*NUM_DIGITS-1:0] r;
      logic visto;
      r     = {(7*NUM_DIGITS){1'b1}};
      visto = 1'b0;
      for (int i = NUM_DIGITS-1; i >= 0; i--) begin
         if (estouro) begin
            r[7*i +: 7] = SEG_TRACO;
         end else if ((b[4*i +: 4] != 4'd0) || visto || (i == 0)) begin
            r[7*i +: 7] = seg7(b[4*i +: 4]);
            visto       = 1'b1;
         end else begin
            r[7*i +: 7] = SEG_APAGADO;
         end
      end
      return r;
   endfunction

   // Next-state and datapath logic for the conversion / acknowledge sequence.
   always_comb begin
      estado_s   = estado_r;
      shift_s    = shift_r;
      bcd_s      = bcd_r;
      cnt_s      = cnt_r;
      estouro_s  = estouro_r;
      sinal_s    = sinal_r;
      ocupado_s  = ocupado_r;
      liberado_s = 1'b0;
      displays_s = displays_r;
      negativo_s = negativo_r;
      bcd_aj_s   = soma3(bcd_r);
      case (estado_r)
         OCIOSO: begin
            if (escrever) begin
`ifdef SAIDA_SINAL_EN
               sinal_s = dado[DATA_W-1];
               if (dado[DATA_W-1]) shift_s = ~dado + DATA_W'(1);
               else                shift_s = dado;
`else
               sinal_s = 1'b0;
               shift_s = dado;
`endif
               bcd_s     = {BCD_W{1'b0}};
               cnt_s     = {CNT_W{1'b0}};
               estouro_s = 1'b0;
               ocupado_s = 1'b1;
               estado_s  = CONVERTE;
            end else begin
               estado_s = OCIOSO;
            end
         end
         CONVERTE: begin
            if (cnt_r == CNT_FIM) begin
               // A bit lost off the top digit also counts as overflow.
               displays_s = codifica(bcd_r, estouro_r || (bcd_r[BCD_W-1 -: 4] != 4'd0));
               negativo_s = sinal_r;
               estado_s   = ESPERA;
            end else begin
               bcd_s     = {bcd_aj_s[BCD_W-2:0], shift_r[DATA_W-1]};
               shift_s   = {shift_r[DATA_W-2:0], 1'b0};
               estouro_s = estouro_r | bcd_aj_s[BCD_W-1];
               cnt_s     = cnt_r + CNT_W'(1);
            end
         end
         ESPERA: begin
            if (enter && !enter_q_r) begin
               ocupado_s  = 1'b0;
               liberado_s = 1'b1;
               estado_s   = OCIOSO;
            end else begin
               estado_s = ESPERA;
            end
         end
         default: begin
            ocupado_s = 1'b0;
            estado_s  = OCIOSO;
         end
      endcase
   end

   // State, datapath and output registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado_r   <= OCIOSO;
         shift_r    <= {DATA_W{1'b0}};
         bcd_r      <= {BCD_W{1'b0}};
         cnt_r      <= {CNT_W{1'b0}};
         estouro_r  <= 1'b0;
         sinal_r    <= 1'b0;
         ocupado_r  <= 1'b0;
         liberado_r <= 1'b0;
         displays_r <= {(7*NUM_DIGITS){1'b1}};
         negativo_r <= 1'b0;
      end else begin
         estado_r   <= estado_s;
         shift_r    <= shift_s;
         bcd_r      <= bcd_s;
         cnt_r      <= cnt_s;
         estouro_r  <= estouro_s;
         sinal_r    <= sinal_s;
         ocupado_r  <= ocupado_s;
         liberado_r <= liberado_s;
         displays_r <= displays_s;
         negativo_r <= negativo_s;
      end
   end

   // Previous enter level, tracked in every state for edge detection.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) enter_q_r <= 1'b0;
      else       enter_q_r <= enter;
   end

   assign ocupado  = ocupado_r;
   assign liberado = liberado_r;
   assign displays = displays_r;
   assign negativo = negativo_r;

endmodule

// File: tb/tb_saida_dados.sv
// Randomized bench for saida_dados: decimal display model computed by arithmetic division.
module tb_saida_dados;

   localparam int DW   = 18;
   localparam int DW20 = 20;
   localparam int ND   = 6;
   localparam logic [7*ND-1:0] BLANK = {(7*ND){1'b1}};

   logic clock = 1'b0;
   logic reset;
   logic escrever, enter, ocupado, liberado, negativo;
   logic [DW-1:0] dado;
   logic [7*ND-1:0] displays;
   logic escrever20, enter20, ocupado20, liberado20, negativo20;
   logic [DW20-1:0] dado20;
   logic [7*ND-1:0] displays20;

   int n_cmp = 0;
   int n_err = 0;
   logic [7*ND-1:0] exp_disp;
   logic exp_neg;

   saida_dados #(.DATA_W(DW), .NUM_DIGITS(ND)) u_dut (
      .clock(clock), .reset(reset), .escrever(escrever), .dado(dado), .enter(enter),
      .ocupado(ocupado), .liberado(liberado), .displays(displays), .negativo(negativo));

   saida_dados #(.DATA_W(DW20), .NUM_DIGITS(ND)) u_dut20 (
      .clock(clock), .reset(reset), .escrever(escrever20), .dado(dado20), .enter(enter20),
      .ocupado(ocupado20), .liberado(liberado20), .displays(displays20), .negativo(negativo20));

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_cmp++;
      if (obs !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [6:0] seg_ref(input longint d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'h7F;
      endcase
   endfunction

   function automatic longint mag(input longint v, input int w);
`ifdef SAIDA_SINAL_EN
      if (v >= (longint'(1) << (w-1))) return (longint'(1) << w) - v;
`endif
      return v;
   endfunction

   function automatic logic neg_ref(input longint v, input int w);
`ifdef SAIDA_SINAL_EN
      return v >= (longint'(1) << (w-1));
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [7*ND-1:0] disp_ref(input longint m);
      logic [7*ND-1:0] r;
      longint lim = 1;
      longint p = 1;
      for (int i = 0; i < ND; i++) lim = lim * 10;
      for (int i = 0; i < ND; i++) begin
         if (m >= lim)              r[7*i +: 7] = 7'b0111111;
         else if (i > 0 && m < p)   r[7*i +: 7] = 7'h7F;
         else                       r[7*i +: 7] = seg_ref((m / p) % 10);
         p = p * 10;
      end
      return r;
   endfunction

   task automatic convert(input logic [DW-1:0] v, input bit spurious, input bit hold_enter);
      escrever = 1'b1;
      dado     = v;
      step();
      escrever = 1'b0;
      dado     = DW'($urandom);
      chk("accept_ocupado", ocupado, 1);
      chk("accept_liberado", liberado, 0);
      for (int i = 1; i <= DW; i++) begin
         if (spurious && i == 5) begin
            escrever = 1'b1;
            dado     = 18'd5;
         end
         if (hold_enter && i == 10) enter = 1'b1;
         step();
         escrever = 1'b0;
         if (i == DW) chk("disp_before_done", displays, exp_disp);
      end
      step();
      exp_disp = disp_ref(mag(longint'(v), DW));
      exp_neg  = neg_ref(longint'(v), DW);
      chk("disp", displays, exp_disp);
      chk("negativo", negativo, exp_neg);
      chk("ocupado_wait", ocupado, 1);
   endtask

   task automatic ack(input bit chain);
      if (enter) begin
         repeat (3) begin
            step();
            chk("held_no_lib", liberado, 0);
            chk("held_ocupado", ocupado, 1);
         end
         enter = 1'b0;
         step();
         chk("release_no_lib", liberado, 0);
      end
      repeat ($urandom_range(0, 3)) begin
         step();
         chk("wait_ocupado", ocupado, 1);
         chk("wait_no_lib", liberado, 0);
      end
      enter = 1'b1;
      step();
      chk("liberado", liberado, 1);
      chk("ocupado_clr", ocupado, 0);
      chk("disp_hold", displays, exp_disp);
      enter = 1'b0;
      if (!chain) begin
         step();
         chk("liberado_one", liberado, 0);
      end
   endtask

   task automatic convert20(input logic [DW20-1:0] v);
      escrever20 = 1'b1;
      dado20     = v;
      step();
      escrever20 = 1'b0;
      chk("w20_ocupado", ocupado20, 1);
      repeat (DW20 + 1) step();
      chk("w20_disp", displays20, disp_ref(mag(longint'(v), DW20)));
      chk("w20_neg", negativo20, neg_ref(longint'(v), DW20));
      enter20 = 1'b1;
      step();
      chk("w20_liberado", liberado20, 1);
      enter20 = 1'b0;
      step();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [DW-1:0] corners [8];
      logic [DW-1:0] v;
      corners = '{18'd0, 18'h3FFFF, 18'h20000, 18'd7, 18'd99999, 18'd100000, 18'h1FFFF, 18'd9};
      reset = 1'b1; escrever = 1'b0; enter = 1'b0; dado = '0;
      escrever20 = 1'b0; enter20 = 1'b0; dado20 = '0;
      step();
      step();
      chk("rst_disp", displays, BLANK);
      chk("rst_ocupado", ocupado, 0);
      chk("rst_liberado", liberado, 0);
      chk("rst_negativo", negativo, 0);
      chk("rst_disp20", displays20, BLANK);
      reset = 1'b0;
      exp_disp = BLANK;
      exp_neg  = 1'b0;
      step();

      convert(18'd0, 1'b0, 1'b0);
      ack(1'b0);
      convert(18'd262143, 1'b1, 1'b0);
      ack(1'b0);
      convert(18'd77777, 1'b0, 1'b1);
      ack(1'b1);
      convert(18'd42, 1'b0, 1'b0);
      ack(1'b0);

      convert(18'd123, 1'b0, 1'b0);
      reset = 1'b1;
      #1;
      chk("rst_mid_disp", displays, BLANK);
      chk("rst_mid_ocupado", ocupado, 0);
      chk("rst_mid_neg", negativo, 0);
      step();
      chk("rst_mid_liberado", liberado, 0);
      reset = 1'b0;
      exp_disp = BLANK;
      exp_neg  = 1'b0;
      enter = 1'b1;
      repeat (3) begin
         step();
         chk("idle_no_lib", liberado, 0);
         chk("idle_ocupado", ocupado, 0);
         chk("idle_disp", displays, BLANK);
      end
      enter = 1'b0;
      step();

      for (int k = 0; k < 30; k++) begin
         if (k < 8) v = corners[k];
         else       v = DW'($urandom);
         convert(v, 1'($urandom), 1'($urandom));
         ack(1'($urandom));
      end
      step();

      convert20(20'd1000000);
      convert20(20'd999999);
      convert20(20'd0);
      for (int k = 0; k < 4; k++) convert20(DW20'($urandom_range(900000, 1048575)));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/saida_dados.md
Name: saida_dados

Overview:
- Output-side peripheral for the processor; the write direction of the operator I/O path.
- On an OUT instruction the processor pulses a write strobe with an 18-bit value.
- The block converts the value to decimal and drives the board's 7-segment displays.
- It holds the processor stalled until the operator acknowledges with the enter key, then releases it with a one-cycle pulse.

Parameters:
DATA_W, 18, width of the data word from the processor
NUM_DIGITS, 6, number of 7-segment digits driven (defaults satisfy 2^DATA_W-1 <= 10^NUM_DIGITS-1)

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
escrever  input  1  one-cycle write strobe from the processor's OUT instruction
dado  input  DATA_W  value to display, sampled when escrever is accepted
enter  input  1  operator acknowledge key, active-high level, synchronous to clock
ocupado  output  1  high while a value is being converted or awaits acknowledge (processor stalls)
liberado  output  1  one-cycle pulse when the operator has acknowledged
displays  output  7*NUM_DIGITS  segments, active-low; digit i in bits [7i+6:7i] as gfedcba; digit 0 least significant
negativo  output  1  minus-sign indicator (see Optional Feature)

Behaviour:
- Reset (async, any state): state=OCIOSO, ocupado=0, liberado=0, negativo=0, displays all 7'h7F (blank), shift/BCD registers cleared.
- All outputs are registered.
- OCIOSO:
  - escrever=1 latches dado into the shift register, clears the BCD register (NUM_DIGITS+1 digits) and the bit counter, sets ocupado=1, goes to CONVERTE.
  - escrever=0: stay.
- CONVERTE: double-dabble, one bit per cycle, exactly DATA_W cycles. Each cycle:
  - every BCD digit >=5 gets +3;
  - then shift {bcd, shift} left by 1.
  - After the DATA_W-th shift: load displays from the BCD digits, go to ESPERA.
  - Latency: escrever at edge 0 -> displays valid after edge DATA_W+1.
- Display encoding, active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Leading zeros blanked (7'h7F); digit 0 is always shown, so value 0 shows a single "0".
- Overflow: if the extra top BCD digit is nonzero, every digit shows dash (0111111).
- ESPERA:
  - Waits for a rising edge of enter: enter=1 this cycle with a registered enter_q=0.
  - If enter is already high on entry, the operator must release it and press again.
  - On the edge: ocupado<=0, liberado<=1 for one cycle, go to OCIOSO.
  - displays keep their value until the next conversion completes.
- escrever while ocupado=1 is ignored; no queueing, no effect on the conversion in progress.
- escrever in the cycle liberado=1 (state already OCIOSO) is accepted normally.
- enter in OCIOSO or CONVERTE has no effect, but still updates enter_q.
- Reset mid-CONVERTE or mid-ESPERA aborts, blanks the displays, no liberado pulse.

Optional Feature:
SAIDA_SINAL_EN
- Defined:
  - dado is two's complement.
  - If dado[DATA_W-1]=1 the shift register is loaded with the negated magnitude, and negativo<=1 when displays are loaded; otherwise negativo<=0.
  - -2^(DATA_W-1) converts correctly as unsigned magnitude.
  - negativo holds with the displays and is cleared by reset.
- Undefined: dado is unsigned; negativo is constant 0.

Test Plan:
- Reset asserted mid-ESPERA with displays showing 123 -> displays all 7'h7F, ocupado=0, liberado never pulses.
- escrever with dado=0 -> after DATA_W+1 edges digit0=1000000, digits1-5=1111111, ocupado=1; pulse enter -> liberado high exactly one cycle, ocupado=0.
- dado=262143 -> displays read 2,6,2,1,4,3 (msd to lsd) exactly 19 edges after the strobe; second escrever during CONVERTE with dado=5 -> ignored, result unchanged.
- enter held high before conversion ends -> no liberado; release then press -> liberado one cycle later; escrever in the liberado cycle with dado=42 -> accepted, shows 42.
- DATA_W=20, NUM_DIGITS=6, dado=1000000 -> all six digits 0111111 (dash).
- With SAIDA_SINAL_EN, dado=18'h3FFFF -> displays "1", negativo=1; dado=18'h20000 -> 131072, negativo=1; dado=7 -> negativo=0.
